dac_spi_responder: RTL and testbench

Receiving end of the SPI link that the DAC driver uses to drive the LTC2624 quad DAC. It snoops DAC_CS, SPI_SCK, SPI_MOSI and DAC_CLR from the CLK_50M domain, deframes each 32-bit command word, and maintains a shadow of the four input and DAC registers. It is used for on-chip loopback checks, for example confirming that DAC B carries the one-sample-delayed copy of ADC A. It can also be routed to LEDs or a logic analyser.

---
 rtl/dac_spi_responder_pkg.sv | 36 +++
 rtl/dac_spi_responder_if.sv | 11 +
 rtl/dac_spi_responder_sync.sv | 32 +++
 rtl/dac_spi_responder.sv | 158 +++++++++++++++
 tb/tb_dac_spi_responder.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/dac_spi_responder_pkg.sv
// Shared definitions for the LTC2624 SPI responder: command codes, frame
// field positions and FSM state encoding.
package dac_spi_pkg;

  localparam int FRAME_BITS = 32;

  localparam logic [3:0] CMD_WRITE         = 4'h0;
  localparam logic [3:0] CMD_UPDATE        = 4'h1;
  localparam logic [3:0] CMD_WRITE_UPD_ALL = 4'h2;
  localparam logic [3:0] CMD_WRITE_UPD     = 4'h3;
  localparam logic [3:0] CMD_POWER_DOWN    = 4'h4;
  localparam logic [3:0] CMD_NOP           = 4'hF;

  localparam logic [3:0] ADDR_ALL = 4'hF;

  localparam int CMD_HI  = 23;
  localparam int CMD_LO  = 20;
  localparam int ADDR_HI = 19;
  localparam int ADDR_LO = 16;
  localparam int DATA_HI = 15;
  localparam int DATA_LO = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SHIFT  = 2'd1;
  localparam state_t ST_DECODE = 2'd2;

  // One-hot channel select; ADDR_ALL selects every channel.
  function automatic logic [3:0] chan_mask(input logic [3:0] addr);
    logic [3:0] m;
    if (addr == ADDR_ALL) m = 4'hF;
    else                  m = 4'b0001 << addr[1:0];
    return m;
  endfunction

endpackage

// File: rtl/dac_spi_responder_if.sv
// Pin-level bundle of the DAC SPI link. The driver side owns every pin;
// the responder only observes them.
interface dac_spi_responder_if;
  logic DAC_CS;
  logic SPI_SCK;
  logic SPI_MOSI;
  logic DAC_CLR;

  modport master (output DAC_CS, output SPI_SCK, output SPI_MOSI, output DAC_CLR);
  modport slave  (input  DAC_CS, input  SPI_SCK, input  SPI_MOSI, input  DAC_CLR);
endinterface

// File: rtl/dac_spi_responder_sync.sv
// Multi-stage pin synchroniser with rise/fall pulses. The pulses are
// registered from the last two stages so they line up with the cycle in
// which the synchronised level first shows the new value.
module spi_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sr;

  // Shift the pin through the chain and flag transitions at the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sr   <= {sr[STAGES-2:0], pin};
      rise <= sr[STAGES-2] & ~sr[STAGES-1];
      fall <= ~sr[STAGES-2] & sr[STAGES-1];
    end
  end

  assign level = sr[STAGES-1];

endmodule

// File: rtl/dac_spi_responder.sv
// Snoops the LTC2624 SPI link, deframes 32-bit command words and keeps a
// shadow copy of the four input and DAC registers plus power-down state.
module dac_spi_responder
  import dac_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK_50M,
  input  logic                  RST_N,
  dac_spi_responder_if.slave    spi,
  output logic [47:0]           vout,
  output logic [3:0]            upd_mask,
  output logic [3:0]            pd_mask,
  output logic [3:0]            last_cmd,
  output logic                  frame_err,
  output logic [15:0]           frame_cnt,
  output state_t                fsm_state
);

  logic cs_rise, cs_fall, sck_rise, mosi_s, clr_s, clr_fall;
  logic unused_cs_lvl, unused_sck_lvl, unused_sck_fall;
  logic unused_mosi_rise, unused_mosi_fall, unused_clr_rise;

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_cs (
    .clk(CLK_50M), .rst_n(RST_N), .pin(spi.DAC_CS),
    .level(unused_cs_lvl), .rise(cs_rise), .fall(cs_fall));
  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sck (
    .clk(CLK_50M), .rst_n(RST_N), .pin(spi.SPI_SCK),
    .level(unused_sck_lvl), .rise(sck_rise), .fall(unused_sck_fall));
  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_mosi (
    .clk(CLK_50M), .rst_n(RST_N), .pin(spi.SPI_MOSI),
    .level(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall));
  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_clr (
    .clk(CLK_50M), .rst_n(RST_N), .pin(spi.DAC_CLR),
    .level(clr_s), .rise(unused_clr_rise), .fall(clr_fall));

  state_t          state;
  logic [5:0]      bit_cnt;
  logic [31:0]     shreg;
  logic [3:0][11:0] in_reg, dac_reg;

  // Frame deframing FSM. A bit shifted in the same cycle as CS rise is
  // kept, because DECODE looks at the shift register one cycle later.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end
        ST_SHIFT: begin
          if (sck_rise) begin
            shreg <= {shreg[30:0], mosi_s};
            if (bit_cnt != 6'd33) bit_cnt <= bit_cnt + 6'd1;
          end
          if (cs_rise) state <= ST_DECODE;
        end
        ST_DECODE: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  logic [3:0]       cmd, addr, ch;
  logic [11:0]      data;
  logic             accept, reject, addr_ok, cmd_ok;
  logic [3:0][11:0] in_nxt, dac_nxt;
  logic [3:0]       pd_nxt, upd_nxt;
  logic             unused_bits;

  assign cmd         = shreg[CMD_HI:CMD_LO];
  assign addr        = shreg[ADDR_HI:ADDR_LO];
  assign data        = shreg[DATA_HI:DATA_LO];
  assign unused_bits = ^{shreg[31:24], shreg[3:0]};
  assign ch          = chan_mask(addr);
  assign addr_ok     = (addr <= 4'd3) || (addr == ADDR_ALL);
  assign cmd_ok      = cmd inside {CMD_WRITE, CMD_UPDATE, CMD_WRITE_UPD_ALL,
                                   CMD_WRITE_UPD, CMD_POWER_DOWN, CMD_NOP};
  assign accept      = (state == ST_DECODE) && (bit_cnt == 6'(FRAME_BITS)) && addr_ok && cmd_ok;
  assign reject      = (state == ST_DECODE) && !accept;

  // Next register image from the decoded command; a held DAC_CLR overrides it.
  always_comb begin
    in_nxt  = in_reg;
    dac_nxt = dac_reg;
    pd_nxt  = pd_mask;
    upd_nxt = 4'h0;
    if (accept) begin
      case (cmd)
        CMD_WRITE: begin
          for (int i = 0; i < 4; i++) if (ch[i]) in_nxt[i] = data;
        end
        CMD_UPDATE: begin
          for (int i = 0; i < 4; i++) if (ch[i]) dac_nxt[i] = in_reg[i];
          upd_nxt = ch;
          pd_nxt  = pd_mask & ~ch;
        end
        CMD_WRITE_UPD_ALL: begin
          for (int i = 0; i < 4; i++) if (ch[i]) in_nxt[i] = data;
          dac_nxt = in_nxt;
          upd_nxt = 4'hF;
          pd_nxt  = 4'h0;
        end
        CMD_WRITE_UPD: begin
          for (int i = 0; i < 4; i++) begin
            if (ch[i]) begin
              in_nxt[i]  = data;
              dac_nxt[i] = data;
            end
          end
          upd_nxt = ch;
          pd_nxt  = pd_mask & ~ch;
        end
        CMD_POWER_DOWN: pd_nxt = pd_mask | ch;
        default: ;
      endcase
    end
    if (!clr_s) begin
      in_nxt  = '0;
      dac_nxt = '0;
      upd_nxt = clr_fall ? 4'hF : 4'h0;
    end
  end

  // Register the shadow image and frame bookkeeping.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      in_reg    <= '0;
      dac_reg   <= '0;
      pd_mask   <= '0;
      upd_mask  <= '0;
      frame_err <= 1'b0;
      last_cmd  <= '0;
      frame_cnt <= '0;
    end else begin
      in_reg    <= in_nxt;
      dac_reg   <= dac_nxt;
      pd_mask   <= pd_nxt;
      upd_mask  <= upd_nxt;
      frame_err <= reject;
      if (accept) begin
        last_cmd  <= cmd;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign vout      = dac_reg;
  assign fsm_state = state;

endmodule

// File: tb/tb_dac_spi_responder.sv
// Directed bench for dac_spi_responder. Each frame pushes its hand-computed
// output image; a monitor pops and compares on every output event.
module tb_dac_spi_responder;

  localparam int W = 77; // {vout48, upd4, pd4, cmd4, err1, cnt16}

  logic        CLK_50M;
  logic        RST_N;
  logic [47:0] vout;
  logic [3:0]  upd_mask, pd_mask, last_cmd;
  logic        frame_err;
  logic [15:0] frame_cnt;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  dac_spi_responder_if spi_if ();

  dac_spi_responder #(.SYNC_STAGES(2)) dut (
    .CLK_50M(CLK_50M), .RST_N(RST_N), .spi(spi_if),
    .vout(vout), .upd_mask(upd_mask), .pd_mask(pd_mask),
    .last_cmd(last_cmd), .frame_err(frame_err), .frame_cnt(frame_cnt),
    .fsm_state(fsm_state));

  // Clock / reset
  initial begin
    CLK_50M = 1'b0;
    forever #10 CLK_50M = ~CLK_50M;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [47:0] v, input logic [3:0] upd, input logic [3:0] pd,
                      input logic [3:0] cmd, input logic err, input logic [15:0] cnt);
    exp_q.push_back({v, upd, pd, cmd, err, cnt});
  endtask

  // Driver tasks
  task automatic cs_low();
    @(negedge CLK_50M);
    spi_if.DAC_CS = 1'b0;
    repeat (3) @(negedge CLK_50M);
  endtask

  task automatic send_bit(input logic b);
    spi_if.SPI_MOSI = b;
    repeat (3) @(negedge CLK_50M);
    spi_if.SPI_SCK = 1'b1;
    repeat (3) @(negedge CLK_50M);
    spi_if.SPI_SCK = 1'b0;
  endtask

  task automatic cs_high_wait(input string name);
    int n;
    repeat (3) @(negedge CLK_50M);
    spi_if.DAC_CS = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge CLK_50M);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no output event, expected %0d pending", name, exp_q.size());
      exp_q.delete();
    end
    repeat (10) @(negedge CLK_50M);
  endtask

  task automatic send_frame(input string name, input logic [32:0] w, input int nbits);
    cs_low();
    for (int i = nbits - 1; i >= 0; i--) send_bit(w[i]);
    cs_high_wait(name);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_vout"},      64'(vout),      64'h0);
    check({tag, "_upd_mask"},  64'(upd_mask),  64'h0);
    check({tag, "_pd_mask"},   64'(pd_mask),   64'h0);
    check({tag, "_last_cmd"},  64'(last_cmd),  64'h0);
    check({tag, "_frame_err"}, 64'(frame_err), 64'h0);
    check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'h0);
    check({tag, "_fsm_state"}, 64'(fsm_state), 64'h0);
  endtask

  // Scoreboard monitor: an output event is any upd/err pulse or count change.
  initial begin
    logic [15:0]  prev_cnt;
    logic [W-1:0] act, exp;
    prev_cnt = '0;
    forever begin
      @(negedge CLK_50M);
      if (!RST_N) begin
        prev_cnt = frame_cnt;
      end else if (upd_mask != 4'h0 || frame_err || frame_cnt != prev_cnt) begin
        act = {vout, upd_mask, pd_mask, last_cmd, frame_err, frame_cnt};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got %h expected no event", act);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            errors++;
            $display("FAIL event: got vout=%h upd=%b pd=%b cmd=%h err=%b cnt=%0d expected vout=%h upd=%b pd=%b cmd=%h err=%b cnt=%0d",
                     act[76:29], act[28:25], act[24:21], act[20:17], act[16], act[15:0],
                     exp[76:29], exp[28:25], exp[24:21], exp[20:17], exp[16], exp[15:0]);
          end
        end
        prev_cnt = frame_cnt;
      end
    end
  end

  // Stimulus
  initial begin
    logic [31:0] w;
    RST_N           = 1'b0;
    spi_if.DAC_CS   = 1'b1;
    spi_if.SPI_SCK  = 1'b0;
    spi_if.SPI_MOSI = 1'b0;
    spi_if.DAC_CLR  = 1'b1;
    repeat (5) @(negedge CLK_50M);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK_50M);
    check_reset_state("reset");

    push(48'h000_000_000_800, 4'b0001, 4'b0000, 4'h3, 1'b0, 16'd1);
    send_frame("wr_upd_a", 33'h0_0030_8000, 32);

    push(48'h000_000_000_800, 4'b0000, 4'b0000, 4'h0, 1'b0, 16'd2);
    send_frame("write_b", 33'h0_0001_ABC0, 32);

    push(48'h000_000_ABC_800, 4'b0010, 4'b0000, 4'h1, 1'b0, 16'd3);
    send_frame("update_b", 33'h0_0011_0000, 32);

    push(48'h555_555_555_555, 4'b1111, 4'b0000, 4'h3, 1'b0, 16'd4);
    send_frame("wr_upd_all", 33'h0_003F_5550, 32);

    push(48'h555_555_555_555, 4'b0000, 4'b0000, 4'h3, 1'b1, 16'd4);
    send_frame("short_31", 33'h0_0030_8000, 31);

    push(48'h555_555_555_555, 4'b0000, 4'b0000, 4'h3, 1'b1, 16'd4);
    send_frame("long_33", 33'h0_0030_8000, 33);

    push(48'h555_555_555_555, 4'b0000, 4'b0000, 4'h3, 1'b1, 16'd4);
    send_frame("bad_addr", 33'h0_0037_1230, 32);

    push(48'h555_555_555_555, 4'b0000, 4'b0100, 4'h4, 1'b0, 16'd5);
    send_frame("pdown_c", 33'h0_0042_0000, 32);

    push(48'h555_456_555_555, 4'b0100, 4'b0000, 4'h3, 1'b0, 16'd6);
    send_frame("wr_upd_c", 33'h0_0032_4560, 32);

    // Input regs now A=555 B=555 C=456 D=555; cmd 2 writes A then loads all.
    push(48'h555_456_555_ABC, 4'b1111, 4'b0000, 4'h2, 1'b0, 16'd7);
    send_frame("wr_upd_all_dac", 33'h0_0020_ABC0, 32);

    push(48'h555_456_555_ABC, 4'b0000, 4'b0000, 4'hF, 1'b0, 16'd8);
    send_frame("nop", 33'h0_00F0_0000, 32);

    push(48'h555_456_555_ABC, 4'b0000, 4'b0000, 4'hF, 1'b1, 16'd8);
    send_frame("bad_cmd", 33'h0_0050_0000, 32);

    // DAC_CLR: registers cleared, one upd pulse, count kept.
    push(48'h0, 4'b1111, 4'b0000, 4'hF, 1'b0, 16'd8);
    @(negedge CLK_50M);
    spi_if.DAC_CLR = 1'b0;
    repeat (15) @(negedge CLK_50M);
    check("clr_queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    spi_if.DAC_CLR = 1'b1;
    repeat (10) @(negedge CLK_50M);

    // Reset at bit 16, released with CS still low: tail of frame ignored.
    w = 32'h0030_8000;
    cs_low();
    for (int i = 31; i >= 16; i--) send_bit(w[i]);
    @(negedge CLK_50M);
    RST_N = 1'b0;
    repeat (3) @(negedge CLK_50M);
    RST_N = 1'b1;
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
    cs_high_wait("aborted");
    check_reset_state("after_abort");

    push(48'h000_000_000_800, 4'b0001, 4'b0000, 4'h3, 1'b0, 16'd1);
    send_frame("post_abort", 33'h0_0030_8000, 32);

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
